// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor: direction counter encodings.
// Optional statistics counters are enabled with the BTB_STATS_EN macro.
package branch_target_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam int STAT_W = 16;

    // Upper half of the counter range means "predict taken".
    function automatic logic ctr_is_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, combinational next-state only.
module branch_target_predictor_sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters; combinational lookup,
// synchronous training. Define BTB_STATS_EN to add lookup/mispredict statistics.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 flush
`ifdef BTB_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_lookups,
    output logic [STAT_W-1:0]    stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    logic [ENTRIES-1:0]   valid_vec;
    logic [TAG_W-1:0]     tag_arr    [ENTRIES];
    logic [WORD_SIZE-1:0] target_arr [ENTRIES];
    logic [1:0]           ctr_arr    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]      lk_tag, upd_tag;

    assign lk_idx  = if_pc[INDEX_BITS-1:0];
    assign lk_tag  = if_pc[WORD_SIZE-1:INDEX_BITS];
    assign upd_idx = upd_pc[INDEX_BITS-1:0];
    assign upd_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];

    // Lookup reads the registered state only, so a same-cycle update is not bypassed.
    assign pred_hit   = valid_vec[lk_idx] && (tag_arr[lk_idx] == lk_tag);
    assign pred_taken = pred_hit && ctr_is_taken(ctr_arr[lk_idx]);
    assign pred_pc    = pred_taken ? target_arr[lk_idx] : if_pc + WORD_SIZE'(1);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                 valid_reg;
            logic [TAG_W-1:0]     tag_reg;
            logic [WORD_SIZE-1:0] target_reg;
            logic [1:0]           ctr_reg;
            logic [1:0]           ctr_next;
            logic                 sel, match;

            assign sel   = upd_valid && (upd_idx == INDEX_BITS'(gi));
            assign match = valid_reg && (tag_reg == upd_tag);

            branch_target_predictor_sat_counter2 u_ctr (
                .ctr      (ctr_reg),
                .inc      (upd_taken),
                .ctr_next (ctr_next)
            );

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WNT;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= CTR_WNT;
                end else if (sel) begin
                    if (match) begin
                        ctr_reg <= ctr_next;
                        if (upd_taken) target_reg <= upd_target;
                    end else if (upd_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target;
                        ctr_reg    <= CTR_WT;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

`ifdef BTB_STATS_EN
    logic [STAT_W-1:0]    stat_lookups_reg, stat_mispredicts_reg;
    logic                 upd_hit, upd_pred_taken, mispredict;
    logic [WORD_SIZE-1:0] upd_pred_target;

    // What the table would have predicted for upd_pc just before this edge.
    assign upd_hit         = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);
    assign upd_pred_taken  = upd_hit && ctr_is_taken(ctr_arr[upd_idx]);
    assign upd_pred_target = target_arr[upd_idx];
    assign mispredict      = (upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lookups_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (flush) begin
            stat_lookups_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (upd_valid) begin
            if (stat_lookups_reg != '1)
                stat_lookups_reg <= stat_lookups_reg + STAT_W'(1);
            if (mispredict && (stat_mispredicts_reg != '1))
                stat_mispredicts_reg <= stat_mispredicts_reg + STAT_W'(1);
        end
    end

    assign stat_lookups     = stat_lookups_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: the driver queues hand-computed lookup results, a negedge monitor checks them.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] if_pc = 16'h0010;
    logic [15:0] pred_pc;
    logic        pred_hit, pred_taken;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        flush = 1'b0;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups, stat_mispredicts;
`endif

    branch_target_predictor #(.WORD_SIZE(16), .INDEX_BITS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_pc      (if_pc),
        .pred_pc    (pred_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush      (flush)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        hit;
        logic        taken;
        bit          chk_stats;
        logic [15:0] lookups;
        logic [15:0] mispredicts;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // One lookup transaction: inputs applied just after a rising edge, checked at the next falling edge.
    task automatic step(input logic [15:0] pc, input logic uv, input logic [15:0] up,
                        input logic ut, input logic [15:0] utg, input logic fl,
                        input logic [15:0] epc, input logic eh, input logic et, input string nm,
                        input bit cs = 1'b0, input logic [15:0] elk = 16'h0,
                        input logic [15:0] emp = 16'h0);
        exp_t e;
        @(posedge clk);
        #1;
        if_pc = pc; upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg; flush = fl;
        e.name = nm; e.pc = epc; e.hit = eh; e.taken = et;
        e.chk_stats = cs; e.lookups = elk; e.mispredicts = emp;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL no_expectation: actual pc=%h required a queued entry", pred_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({pred_pc, pred_hit, pred_taken} !== {e.pc, e.hit, e.taken}) begin
                    failures++;
                    $display("FAIL %s: actual pc=%h hit=%b taken=%b required pc=%h hit=%b taken=%b",
                             e.name, pred_pc, pred_hit, pred_taken, e.pc, e.hit, e.taken);
                end else begin
                    $display("txn %s: if_pc=%h pred_pc=%h hit=%b taken=%b",
                             e.name, if_pc, pred_pc, pred_hit, pred_taken);
                end
`ifdef BTB_STATS_EN
                if (e.chk_stats) begin
                    checks++;
                    if ({stat_lookups, stat_mispredicts} !== {e.lookups, e.mispredicts}) begin
                        failures++;
                        $display("FAIL %s_stats: actual lookups=%0d mispredicts=%0d required lookups=%0d mispredicts=%0d",
                                 e.name, stat_lookups, stat_mispredicts, e.lookups, e.mispredicts);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held: outputs purely combinational.
        step(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 0, "reset", 1'b1, 16'd0, 16'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        step(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 0, "post_reset");
        // Allocate: same-cycle lookup sees old contents.
        step(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0011, 0, 0, "same_cycle");
        step(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 1, 1, "alloc");
        // Hysteresis: ctr 2 -> 1 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2.
        step(16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0040, 1, 1, "ctr2_nt");
        step(16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0011, 1, 0, "ctr1_nt");
        step(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0011, 1, 0, "ctr0_t");
        step(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0011, 1, 0, "ctr1_t");
        step(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0040, 1, 1, "ctr2_t");
        step(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0040, 1, 1, "ctr3_t");
        step(16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0040, 1, 1, "ctr3_sat_nt");
        step(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 1, 1, "ctr2_after_sat");
        // Alias: same index, different tag.
        step(16'h0110, 0, 16'h0000, 0, 16'h0000, 0, 16'h0111, 0, 0, "alias_miss");
        step(16'h0110, 1, 16'h0110, 1, 16'h0200, 0, 16'h0111, 0, 0, "alias_upd");
        step(16'h0110, 0, 16'h0000, 0, 16'h0000, 0, 16'h0200, 1, 1, "alias_alloc");
        step(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 0, "alias_evict");
        // Not-taken miss must not allocate.
        step(16'h0030, 1, 16'h0030, 0, 16'h0000, 0, 16'h0031, 0, 0, "nt_miss_upd");
        step(16'h0030, 0, 16'h0000, 0, 16'h0000, 0, 16'h0031, 0, 0, "nt_noalloc");
        // Taken hit retargets the entry.
        step(16'h0110, 1, 16'h0110, 1, 16'h0300, 0, 16'h0200, 1, 1, "retarget_upd");
        step(16'h0110, 0, 16'h0000, 0, 16'h0000, 0, 16'h0300, 1, 1, "retarget");
        // Flush beats a simultaneous allocate.
        step(16'h0020, 1, 16'h0020, 1, 16'h0050, 1, 16'h0021, 0, 0, "flush_cycle");
        step(16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 16'h0021, 0, 0, "flush_drop", 1'b1, 16'd0, 16'd0);
        step(16'h0110, 0, 16'h0000, 0, 16'h0000, 0, 16'h0111, 0, 0, "flush_clear");
        // Wrap, then three updates with a single mispredict (the first, allocating one).
        step(16'hFFFF, 1, 16'h0070, 1, 16'h0090, 0, 16'h0000, 0, 0, "wrap");
        step(16'h0070, 1, 16'h0070, 1, 16'h0090, 0, 16'h0090, 1, 1, "stat_upd2");
        step(16'h0070, 1, 16'h0070, 1, 16'h0090, 0, 16'h0090, 1, 1, "stat_upd3");
        step(16'h0070, 0, 16'h0000, 0, 16'h0000, 0, 16'h0090, 1, 1, "stats", 1'b1, 16'd3, 16'd1);
        @(negedge clk);
        #1 chk_valid = 1'b0;
        upd_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: actual %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
